// File: rtl/vga_timing_ctrl.sv
// VGA timing generator and pin output stage: scan counters, renderer coordinates,
// sync/blank delay line matched to the renderer latency, and registered RGB/sync pins.
module vga_timing_ctrl #(
    parameter int H_ACTIVE     = 1280,
    parameter int H_FP         = 72,
    parameter int H_SYNC       = 128,
    parameter int H_BP         = 200,
    parameter int V_ACTIVE     = 800,
    parameter int V_FP         = 3,
    parameter int V_SYNC       = 6,
    parameter int V_BP         = 22,
    parameter bit H_POL        = 1'b0,
    parameter bit V_POL        = 1'b1,
    parameter int PIPE_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] curr_x,
    output logic [9:0]  curr_y,
    input  logic [3:0]  i_pix_r,
    input  logic [3:0]  i_pix_g,
    input  logic [3:0]  i_pix_b,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start,
    output logic        vblank
);

    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] HS_BEGIN = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0]  VS_BEGIN = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0]  V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic [10:0] h_cnt_reg, h_cnt_next;
    logic [9:0]  v_cnt_reg, v_cnt_next;
    logic        de_raw, hs_raw, vs_raw;
    logic        de_d, hs_d, vs_d;

    always_comb begin
        h_cnt_next = h_cnt_reg + 11'd1;
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
        end else begin
            h_cnt_reg <= h_cnt_next;
            v_cnt_reg <= v_cnt_next;
        end
    end

    always_comb begin
        de_raw      = (h_cnt_reg < H_ACT) && (v_cnt_reg < V_ACT);
        hs_raw      = (h_cnt_reg >= HS_BEGIN) && (h_cnt_reg < HS_END);
        vs_raw      = (v_cnt_reg >= VS_BEGIN) && (v_cnt_reg < VS_END);
        curr_x      = de_raw ? h_cnt_reg : '0;
        curr_y      = de_raw ? v_cnt_reg : '0;
        frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
        vblank      = (v_cnt_reg >= V_ACT);
    end

    // Delay line carries asserted-sync flags (not pin levels) so a cleared stage means idle syncs.
    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LATENCY; gi++) begin : g_dly
            logic [2:0] stage_reg;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) stage_reg <= '0;
                    else      stage_reg <= {de_raw, hs_raw, vs_raw};
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) stage_reg <= '0;
                    else      stage_reg <= g_dly[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign {de_d, hs_d, vs_d} = g_dly[PIPE_LATENCY-1].stage_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~H_POL;
            vga_vs <= ~V_POL;
        end else begin
            vga_r  <= de_d ? i_pix_r : '0;
            vga_g  <= de_d ? i_pix_g : '0;
            vga_b  <= de_d ? i_pix_b : '0;
            vga_hs <= hs_d ? H_POL : ~H_POL;
            vga_vs <= vs_d ? V_POL : ~V_POL;
        end
    end

endmodule
